// File: rtl/ascon_sequencer_pkg.sv
// ============================================================================
// Module      : ascon_sequencer_pkg
// Description : Shared types and constants for the Ascon-AEAD128 sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ascon_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        AD    = 3'd2,
        MSG   = 3'd3,
        FINAL = 3'd4
    } seq_state_t;

    // Key-injection select: bit 0 puts K into s3|s4, bit 1 puts K into s2|s3
    localparam logic [1:0] c_key_xor_none  = 2'b00;
    localparam logic [1:0] c_key_xor_init  = 2'b01;
    localparam logic [1:0] c_key_xor_final = 2'b10;
    localparam logic [1:0] c_key_xor_both  = 2'b11;

    localparam logic [3:0] c_last_rnd = 4'd11;

    // First round index of a permutation with the given number of rounds
    function automatic logic [3:0] first_rnd(input int rounds);
        return 4'(12 - rounds);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ascon_sequencer_round_counter.sv
// ============================================================================
// Module      : ascon_sequencer_round_counter
// Description : 4-bit permutation round index with load, increment and
//               last-round flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_sequencer_round_counter
    import ascon_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_en,
    output logic [3:0] o_rnd,
    output logic       o_last
);

    logic [3:0] r_rnd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rnd <= 4'd0;
        end else if (i_load) begin
            r_rnd <= i_load_val;
        end else if (i_en) begin
            r_rnd <= r_rnd + 4'd1;
        end
    end

    assign o_rnd  = r_rnd;
    assign o_last = (r_rnd == c_last_rnd);

endmodule

`default_nettype wire

// File: rtl/ascon_sequencer.sv
// ============================================================================
// Module      : ascon_sequencer
// Description : Control FSM for the Ascon-AEAD128 encryption datapath; data
//               and key XORs are merged into the last round of each permutation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_sequencer
    import ascon_sequencer_pkg::*;
#(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       ad_empty,
    input  logic       ad_valid,
    input  logic       ad_last,
    output logic       ad_ready,
    input  logic       db_valid,
    input  logic       db_last,
    output logic       db_ready,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       tag_valid,
    input  logic       tag_ready,
    output logic       busy,
    output logic       done,
    output logic [3:0] rnd,
    output logic       en_internal,
    output logic       en_new_key,
    output logic       sel_state,
    output logic       sel_din,
    output logic       sel_dout,
    output logic       sel_xor_data,
    output logic       end_ad,
    output logic [1:0] sel_xor_key
);

    localparam logic [3:0] c_rnd_a = first_rnd(ROUNDS_A);
    localparam logic [3:0] c_rnd_b = first_rnd(ROUNDS_B);

    seq_state_t r_state;
    seq_state_t w_next_state;
    logic       r_ad_empty;
    logic       r_ad_done;
    logic       r_done;

    logic       w_last;
    logic       w_cnt_load;
    logic [3:0] w_cnt_load_val;
    logic       w_cnt_en;
    logic       w_start_acc;
    logic       w_ad_xfer;
    logic       w_done_nxt;
    logic       w_ad_absorb;
    logic       w_msg_absorb;
    logic [1:0] w_key_base;

    ascon_sequencer_round_counter u_round_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_en       (w_cnt_en),
        .o_rnd      (rnd),
        .o_last     (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ad_empty <= 1'b0;
            r_ad_done  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_done_nxt;
            if (w_start_acc) begin
                r_ad_empty <= ad_empty;
                r_ad_done  <= 1'b0;
            end else if (w_ad_xfer) begin
                r_ad_done <= ad_last;
            end
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = 4'd0;
        w_cnt_en       = 1'b0;
        w_start_acc    = 1'b0;
        w_ad_xfer      = 1'b0;
        w_done_nxt     = 1'b0;
        w_ad_absorb    = 1'b0;
        w_msg_absorb   = 1'b0;
        w_key_base     = c_key_xor_none;
        ad_ready       = 1'b0;
        db_ready       = 1'b0;
        dout_valid     = 1'b0;
        tag_valid      = 1'b0;
        en_internal    = 1'b0;
        en_new_key     = 1'b0;
        sel_state      = 1'b0;
        sel_din        = 1'b0;
        sel_dout       = 1'b0;
        sel_xor_data   = 1'b0;
        end_ad         = 1'b0;
        sel_xor_key    = c_key_xor_none;

        // Everything is suppressed under reset so no held block is consumed
        if (!rst) begin
            if (r_state == IDLE) begin
                if (start) begin
                    w_start_acc    = 1'b1;
                    en_new_key     = 1'b1;
                    sel_state      = 1'b1;
                    en_internal    = 1'b1;
                    w_next_state   = INIT;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = c_rnd_a;
                end
            end else if (!w_last) begin
                en_internal = 1'b1;
                w_cnt_en    = 1'b1;
            end else begin
                unique case (r_state)
                    INIT: begin
                        w_key_base = c_key_xor_init;
                        if (r_ad_empty) begin
                            w_msg_absorb = 1'b1;
                            end_ad       = 1'b1;
                        end else begin
                            w_ad_absorb = 1'b1;
                        end
                    end
                    AD: begin
                        if (r_ad_done) begin
                            w_msg_absorb = 1'b1;
                            end_ad       = 1'b1;
                        end else begin
                            w_ad_absorb = 1'b1;
                        end
                    end
                    MSG: begin
                        w_msg_absorb = 1'b1;
                    end
                    FINAL: begin
                        tag_valid   = 1'b1;
                        sel_dout    = 1'b1;
                        sel_xor_key = c_key_xor_init;
                        if (tag_ready) begin
                            en_internal  = 1'b1;
                            w_next_state = IDLE;
                            w_cnt_load   = 1'b1;
                            w_done_nxt   = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (w_ad_absorb) begin
                ad_ready     = 1'b1;
                sel_xor_data = 1'b1;
                sel_xor_key  = w_key_base;
                if (ad_valid) begin
                    w_ad_xfer      = 1'b1;
                    en_internal    = 1'b1;
                    w_next_state   = AD;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = c_rnd_b;
                end
            end

            // Ciphertext leaves in the same cycle the plaintext is absorbed
            if (w_msg_absorb) begin
                db_ready     = dout_ready;
                dout_valid   = db_valid;
                sel_din      = 1'b1;
                sel_xor_data = 1'b1;
                if (db_last) begin
                    sel_xor_key = (w_key_base == c_key_xor_init) ? c_key_xor_both : c_key_xor_final;
                end else begin
                    sel_xor_key = w_key_base;
                end
                if (db_valid && dout_ready) begin
                    en_internal    = 1'b1;
                    w_next_state   = db_last ? FINAL : MSG;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = db_last ? c_rnd_a : c_rnd_b;
                end
            end
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ascon_sequencer.sv
// ============================================================================
// Module      : tb_ascon_sequencer
// Description : Self-checking bench for ascon_sequencer against a schedule
//               model of permutations and boundary transfers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ascon_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, ad_empty, ad_valid, ad_last, db_valid, db_last, dout_ready, tag_ready;
    logic       ad_ready, db_ready, dout_valid, tag_valid, busy, done;
    logic [3:0] rnd;
    logic       en_internal, en_new_key, sel_state, sel_din, sel_dout, sel_xor_data, end_ad;
    logic [1:0] sel_xor_key;
    logic [18:0] act;

    ascon_sequencer #(.ROUNDS_A(12), .ROUNDS_B(8)) dut (
        .clk(clk), .rst(rst), .start(start), .ad_empty(ad_empty),
        .ad_valid(ad_valid), .ad_last(ad_last), .ad_ready(ad_ready),
        .db_valid(db_valid), .db_last(db_last), .db_ready(db_ready),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .tag_valid(tag_valid), .tag_ready(tag_ready),
        .busy(busy), .done(done), .rnd(rnd),
        .en_internal(en_internal), .en_new_key(en_new_key), .sel_state(sel_state),
        .sel_din(sel_din), .sel_dout(sel_dout), .sel_xor_data(sel_xor_data),
        .end_ad(end_ad), .sel_xor_key(sel_xor_key)
    );

    // [18] en_internal .. [12] end_ad, [11:10] key, [9] ad_ready, [8] db_ready,
    // [7] dout_valid, [6] tag_valid, [5] busy, [4] done, [3:0] rnd
    assign act = {en_internal, en_new_key, sel_state, sel_din, sel_dout, sel_xor_data, end_ad,
                  sel_xor_key, ad_ready, db_ready, dout_valid, tag_valid, busy, done, rnd};

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 AD block, 1 data block, 2 tag
        int idx;
        int first;
        int st;
        int rounds;
        int arrive;
        int xfer;
    } seg_t;

    int total = 0;
    int bad   = 0;
    int p_nad, p_ndb, p_stall_mode, p_start_mode, p_stop;
    int p_stall [0:15];
    int last_xfer;
    logic [18:0] q_act [$];
    logic [18:0] q_exp [$];

    task automatic plan_clear();
        for (int i = 0; i < 16; i++) p_stall[i] = 0;
        p_stall_mode = 0;
        p_start_mode = 0;
        p_stop       = -1;
    endtask

    // Drives one operation cycle by cycle and records observed and predicted outputs
    task automatic run_op();
        seg_t segs [$];
        seg_t sg;
        int st, rounds, n_seg, t_end, w;
        logic [1:0] r2, k;
        logic e_int, e_nk, e_ss, e_din, e_dout, e_xd, e_ead, e_ar, e_dr, e_dv, e_tv, e_busy, e_done;
        logic [3:0] e_rnd;
        q_act.delete();
        q_exp.delete();
        st     = 1;
        rounds = 12;
        n_seg  = p_nad + p_ndb + 1;
        for (int i = 0; i < n_seg; i++) begin
            sg.kind   = (i < p_nad) ? 0 : (i < p_nad + p_ndb) ? 1 : 2;
            sg.idx    = (sg.kind == 0) ? i : (sg.kind == 1) ? i - p_nad : 0;
            sg.first  = (i == 0) ? 1 : 0;
            sg.st     = st;
            sg.rounds = rounds;
            sg.arrive = st + rounds - 1;
            sg.xfer   = sg.arrive + p_stall[i];
            segs.push_back(sg);
            st     = sg.xfer + 1;
            rounds = (sg.kind == 1 && sg.idx == p_ndb - 1) ? 12 : 8;
        end
        last_xfer = segs[n_seg-1].xfer;
        t_end = (p_stop >= 0) ? p_stop - 1 : last_xfer + 2;

        for (int t = 0; t <= t_end; t++) begin
            @(posedge clk);
            #1;
            w = -1;
            for (int i = 0; i < n_seg; i++)
                if (t >= segs[i].st && t <= segs[i].xfer) w = i;
            start = (t == 0) ? 1'b1 : (t <= last_xfer) ? (p_start_mode == 1 || $urandom_range(0, 1) == 1) : 1'b0;
            ad_empty   = (t == 0) ? (p_nad == 0) : ($urandom_range(0, 1) == 1);
            ad_valid   = ($urandom_range(0, 1) == 1);
            ad_last    = ($urandom_range(0, 1) == 1);
            db_valid   = ($urandom_range(0, 1) == 1);
            db_last    = ($urandom_range(0, 1) == 1);
            dout_ready = ($urandom_range(0, 1) == 1);
            tag_ready  = ($urandom_range(0, 1) == 1);
            if (w >= 0 && t >= segs[w].arrive) begin
                case (segs[w].kind)
                    0: begin
                        ad_valid = (t == segs[w].xfer);
                        ad_last  = (segs[w].idx == p_nad - 1);
                    end
                    1: begin
                        db_last = (segs[w].idx == p_ndb - 1);
                        if (t == segs[w].xfer) begin
                            db_valid   = 1'b1;
                            dout_ready = 1'b1;
                        end else if (p_stall_mode == 1) begin
                            db_valid   = 1'b1;
                            dout_ready = 1'b0;
                        end else begin
                            r2 = 2'($urandom_range(0, 2));
                            db_valid   = r2[1];
                            dout_ready = r2[0];
                        end
                    end
                    default: tag_ready = (t == segs[w].xfer);
                endcase
            end

            @(negedge clk);
            {e_int, e_nk, e_ss, e_din, e_dout, e_xd, e_ead, e_ar, e_dr, e_dv, e_tv, e_busy, e_done} = '0;
            k     = 2'b00;
            e_rnd = 4'd0;
            if (t == 0) begin
                e_int = 1'b1;
                e_nk  = 1'b1;
                e_ss  = 1'b1;
            end else if (t <= last_xfer) begin
                e_busy = 1'b1;
                if (t < segs[w].arrive) begin
                    e_int = 1'b1;
                    e_rnd = 4'(12 - segs[w].rounds + (t - segs[w].st));
                end else begin
                    e_rnd = 4'd11;
                    e_int = (t == segs[w].xfer);
                    case (segs[w].kind)
                        0: begin
                            e_ar = 1'b1;
                            e_xd = 1'b1;
                            k    = 2'(segs[w].first);
                        end
                        1: begin
                            e_dr  = dout_ready;
                            e_dv  = db_valid;
                            e_din = 1'b1;
                            e_xd  = 1'b1;
                            e_ead = (segs[w].idx == 0);
                            k     = 2'(segs[w].first) | ((segs[w].idx == p_ndb - 1) ? 2'b10 : 2'b00);
                        end
                        default: begin
                            e_tv   = 1'b1;
                            e_dout = 1'b1;
                            k      = 2'b01;
                        end
                    endcase
                end
            end else if (t == last_xfer + 1) begin
                e_done = 1'b1;
            end
            q_act.push_back(act);
            q_exp.push_back({e_int, e_nk, e_ss, e_din, e_dout, e_xd, e_ead, k,
                             e_ar, e_dr, e_dv, e_tv, e_busy, e_done, e_rnd});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; ad_empty = 1'b0; ad_valid = 1'b0; ad_last = 1'b0;
        db_valid = 1'b0; db_last = 1'b0; dout_ready = 1'b0; tag_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(negedge clk);
        total++;
        if (act !== 19'd0) begin
            bad++;
            $display("FAIL reset_held got=%h want=%h", act, 19'd0);
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        total++;
        if (act !== 19'd0) begin
            bad++;
            $display("FAIL reset_released got=%h want=%h", act, 19'd0);
        end
    endtask

    task automatic test_basic();
        plan_clear();
        p_nad = 0;
        p_ndb = 1;
        run_op();
        foreach (q_act[i]) begin
            total++;
            if (q_act[i] !== q_exp[i]) begin
                bad++;
                $display("FAIL basic cyc=%0d got=%h want=%h", i, q_act[i], q_exp[i]);
            end
        end
        total++;
        if (q_act[12][12:10] !== 3'b111) begin
            bad++;
            $display("FAIL basic_boundary12 end_ad_key got=%b want=111", q_act[12][12:10]);
        end
        total++;
        if (q_act[24][6] !== 1'b1) begin
            bad++;
            $display("FAIL basic_tag24 got=%b want=1", q_act[24][6]);
        end
        total++;
        if (q_act[25][5:4] !== 2'b01) begin
            bad++;
            $display("FAIL basic_done25 busy_done got=%b want=01", q_act[25][5:4]);
        end
    endtask

    task automatic test_two_two();
        plan_clear();
        p_nad = 2;
        p_ndb = 2;
        run_op();
        foreach (q_act[i]) begin
            total++;
            if (q_act[i] !== q_exp[i]) begin
                bad++;
                $display("FAIL two_two cyc=%0d got=%h want=%h", i, q_act[i], q_exp[i]);
            end
        end
        total++;
        if ({q_act[12][9], q_act[20][9], q_act[28][8], q_act[28][12], q_act[36][8]} !== 5'b11111) begin
            bad++;
            $display("FAIL two_two_handshakes got=%b want=11111",
                     {q_act[12][9], q_act[20][9], q_act[28][8], q_act[28][12], q_act[36][8]});
        end
        total++;
        if ({q_act[36][11:10], q_act[48][6], q_act[49][4]} !== 4'b1011) begin
            bad++;
            $display("FAIL two_two_final got=%b want=1011", {q_act[36][11:10], q_act[48][6], q_act[49][4]});
        end
    endtask

    task automatic test_ad_stall();
        plan_clear();
        p_nad = 2;
        p_ndb = 2;
        p_stall[0] = 5;
        run_op();
        foreach (q_act[i]) begin
            total++;
            if (q_act[i] !== q_exp[i]) begin
                bad++;
                $display("FAIL ad_stall cyc=%0d got=%h want=%h", i, q_act[i], q_exp[i]);
            end
        end
        for (int c = 12; c <= 16; c++) begin
            total++;
            if ({q_act[c][18], q_act[c][3:0]} !== 5'b0_1011) begin
                bad++;
                $display("FAIL ad_stall_hold cyc=%0d en_rnd got=%b want=01011", c, {q_act[c][18], q_act[c][3:0]});
            end
        end
        total++;
        if (q_act[53][6] !== 1'b1) begin
            bad++;
            $display("FAIL ad_stall_tag53 got=%b want=1", q_act[53][6]);
        end
    endtask

    task automatic test_dout_stall();
        plan_clear();
        p_nad = 1;
        p_ndb = 2;
        p_stall_mode = 1;
        p_stall[1] = 3;
        run_op();
        foreach (q_act[i]) begin
            total++;
            if (q_act[i] !== q_exp[i]) begin
                bad++;
                $display("FAIL dout_stall cyc=%0d got=%h want=%h", i, q_act[i], q_exp[i]);
            end
        end
        for (int c = 20; c <= 22; c++) begin
            total++;
            if ({q_act[c][18], q_act[c][8], q_act[c][7]} !== 3'b001) begin
                bad++;
                $display("FAIL dout_stall_hold cyc=%0d en_rdy_vld got=%b want=001", c,
                         {q_act[c][18], q_act[c][8], q_act[c][7]});
            end
        end
        total++;
        if ({q_act[23][18], q_act[23][8], q_act[23][7]} !== 3'b111) begin
            bad++;
            $display("FAIL dout_stall_xfer got=%b want=111", {q_act[23][18], q_act[23][8], q_act[23][7]});
        end
    endtask

    task automatic test_mid_reset();
        plan_clear();
        p_nad  = 2;
        p_ndb  = 2;
        p_stop = 31;
        run_op();
        foreach (q_act[i]) begin
            total++;
            if (q_act[i] !== q_exp[i]) begin
                bad++;
                $display("FAIL mid_reset_pre cyc=%0d got=%h want=%h", i, q_act[i], q_exp[i]);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b0; db_valid = 1'b1; dout_ready = 1'b1; ad_valid = 1'b1; tag_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({act[9:6], act[3:0]} !== 8'b0000_0110) begin
            bad++;
            $display("FAIL mid_reset_cycle hs_rnd got=%b want=00000110", {act[9:6], act[3:0]});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (act !== 19'd0) begin
            bad++;
            $display("FAIL mid_reset_after got=%h want=%h", act, 19'd0);
        end
        plan_clear();
        p_nad = 2;
        p_ndb = 2;
        run_op();
        foreach (q_act[i]) begin
            total++;
            if (q_act[i] !== q_exp[i]) begin
                bad++;
                $display("FAIL mid_reset_rerun cyc=%0d got=%h want=%h", i, q_act[i], q_exp[i]);
            end
        end
    endtask

    task automatic test_busy_start();
        int n_done, n_tag_hold;
        plan_clear();
        p_nad = 1;
        p_ndb = 1;
        p_start_mode = 1;
        p_stall[2] = 4;
        run_op();
        n_done = 0;
        n_tag_hold = 0;
        foreach (q_act[i]) begin
            total++;
            if (q_act[i] !== q_exp[i]) begin
                bad++;
                $display("FAIL busy_start cyc=%0d got=%h want=%h", i, q_act[i], q_exp[i]);
            end
            if (q_act[i][4] === 1'b1) n_done++;
            if (q_act[i][6] === 1'b1 && q_act[i][18] === 1'b0) n_tag_hold++;
        end
        total++;
        if (n_done != 1 || n_tag_hold != 4) begin
            bad++;
            $display("FAIL busy_start_counts done=%0d tag_hold=%0d want 1 and 4", n_done, n_tag_hold);
        end
    endtask

    task automatic test_random();
        for (int op = 0; op < 12; op++) begin
            plan_clear();
            p_nad = $urandom_range(0, 3);
            p_ndb = $urandom_range(1, 3);
            for (int i = 0; i < 16; i++) p_stall[i] = $urandom_range(0, 3);
            run_op();
            foreach (q_act[i]) begin
                total++;
                if (q_act[i] !== q_exp[i]) begin
                    bad++;
                    $display("FAIL random op=%0d cyc=%0d got=%h want=%h", op, i, q_act[i], q_exp[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_two_two();
        test_ad_stall();
        test_dout_stall();
        test_mid_reset();
        test_busy_start();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
